// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative 32-bit restoring divider for the EX stage (MIPS DIV/DIVU).
// Produces {remainder, quotient} after 32 single-bit steps and holds the pipeline
// through stallreq while a division is in flight.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   start      level, high while a DIV/DIVU occupies EX
//   signed_div 1 = DIV (two's complement), 0 = DIVU
//   opdata1    dividend (rs)
//   opdata2    divisor (rt)
//   annul      cancel in-flight division (flush/exception)
//   result     {remainder[63:32], quotient[31:0]}, registered
//   ready      result valid for one cycle (combinational: END and not annulled)
//   stallreq   combinational start & ~ready, to the stall controller
module ex_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        stallreq
);

    localparam int unsigned DW = 32;          // operand width
    localparam int unsigned CW = 5;           // step counter width
    localparam int unsigned WW = 2 * DW + 1;  // working register {rem[32:0], quo[31:0]}

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_DBZ  = 2'd1,
        ST_ON   = 2'd2,
        ST_END  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     wr_q, wr_d;
    logic [DW-1:0]     dvs_q, dvs_d;
    logic              sgn1_q, sgn1_d;
    logic              sgn2_q, sgn2_d;
    logic              sdiv_q, sdiv_d;
    logic [2*DW-1:0]   result_q, result_d;

    logic [DW-1:0]     op1_mag_c;
    logic [DW-1:0]     op2_mag_c;
    logic [WW-1:0]     shifted_c;
    logic [DW:0]       trial_c;
    logic [WW-1:0]     step_wr_c;
    logic [DW-1:0]     quo_f_c;
    logic [DW-1:0]     rem_f_c;
    logic              q_neg_c;
    logic              r_neg_c;
    logic [2*DW-1:0]   fin_c;

    // Operand magnitudes; only signed mode negates negative operands.
    always_comb begin
        op1_mag_c = (signed_div && opdata1[DW-1]) ? (~opdata1 + DW'(1)) : opdata1;
        op2_mag_c = (signed_div && opdata2[DW-1]) ? (~opdata2 + DW'(1)) : opdata2;
    end

    // One restoring step: shift, trial subtract, keep trial if non-negative.
    always_comb begin
        shifted_c = {wr_q[WW-2:0], 1'b0};
        trial_c   = shifted_c[WW-1:DW] - {1'b0, dvs_q};
        if (trial_c[DW]) begin
            step_wr_c = shifted_c;
        end else begin
            step_wr_c = {trial_c, shifted_c[DW-1:1], 1'b1};
        end
    end

    // Sign correction of the final step; the -2^31 / -1 case wraps naturally.
    always_comb begin
        quo_f_c = step_wr_c[DW-1:0];
        rem_f_c = step_wr_c[2*DW-1:DW];
        q_neg_c = sdiv_q & (sgn1_q ^ sgn2_q);
        r_neg_c = sdiv_q & sgn1_q;
        fin_c   = {(r_neg_c ? (~rem_f_c + DW'(1)) : rem_f_c),
                   (q_neg_c ? (~quo_f_c + DW'(1)) : quo_f_c)};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        dvs_d    = dvs_q;
        sgn1_d   = sgn1_q;
        sgn2_d   = sgn2_q;
        sdiv_d   = sdiv_q;
        result_d = result_q;

        case (state_q)
            ST_FREE: begin
                if (start) begin
                    if (opdata2 == '0) begin
                        state_d = ST_DBZ;
                    end else begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        wr_d    = {{(DW+1){1'b0}}, op1_mag_c};
                        dvs_d   = op2_mag_c;
                        sgn1_d  = opdata1[DW-1];
                        sgn2_d  = opdata2[DW-1];
                        sdiv_d  = signed_div;
                    end
                end
            end
            ST_DBZ: begin
                state_d  = ST_END;
                result_d = '0;
            end
            ST_ON: begin
                wr_d  = step_wr_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d  = ST_END;
                    result_d = fin_c;
                end
            end
            ST_END: begin
                state_d = ST_FREE;
            end
            default: begin
                state_d = ST_FREE;
            end
        endcase

        // Flush wins over everything, including a result about to be loaded.
        if (annul) begin
            state_d  = ST_FREE;
            result_d = result_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FREE;
            cnt_q    <= '0;
            wr_q     <= '0;
            dvs_q    <= '0;
            sgn1_q   <= 1'b0;
            sgn2_q   <= 1'b0;
            sdiv_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            dvs_q    <= dvs_d;
            sgn1_q   <= sgn1_d;
            sgn2_q   <= sgn2_d;
            sdiv_q   <= sdiv_d;
            result_q <= result_d;
        end
    end

    // ready must drop in the same cycle annul arrives, so it is decoded from state.
    assign ready    = (state_q == ST_END) && !annul;
    assign stallreq = start & ~ready;
    assign result   = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed cases plus random divides
// against an arithmetic reference model.
module tb_ex_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_res;

    ex_div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stallreq   (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are sampled 1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts a division in the current (FREE) cycle and waits for ready.
    // Leaves start high; the caller decides what happens after END.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp_res);
        int lat;
        int stalls;
        int exp_lat;
        exp_lat    = (b == 32'd0) ? 2 : 33;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        #1;
        lat    = 0;
        stalls = 0;
        while (ready !== 1'b1 && lat < 100) begin
            if (stallreq === 1'b1) stalls++;
            tick();
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_stall"}, 64'(stalls), 64'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_stall_end"}, 64'(stallreq), 64'd0);
        last_res = exp_res;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;
        last_res   = '0;
        repeat (3) tick();
        #1;
        chk("reset_result", result, 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_stall", 64'(stallreq), 64'd0);
        rst = 1'b0;
        tick();

        // Directed cases.
        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        start = 1'b0; tick();
        #1 chk("free_after_end_ready", 64'(ready), 64'd0);
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        start = 1'b0; tick();
        run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
        start = 1'b0; tick();
        run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000});
        start = 1'b0; tick();
        run_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF});
        start = 1'b0; tick();
        run_div("divu_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b0, {32'd7, 32'd0});
        start = 1'b0; tick();
        run_div("dbz", 32'h1234_5678, 32'd0, 1'b1, 64'd0);
        start = 1'b0; tick();

        // Annul mid-division: no ready, result untouched, restart works.
        opdata1 = 32'd1000; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (10) tick();
        #1 chk("annul_pre_stall", 64'(stallreq), 64'd1);
        annul = 1'b1; start = 1'b0;
        tick();
        annul = 1'b0;
        #1;
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result", result, last_res);
        tick();
        #1 chk("annul_ready2", 64'(ready), 64'd0);
        run_div("divu_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

        // Annul in the END cycle suppresses ready.
        annul = 1'b1;
        #1;
        chk("annul_end_ready", 64'(ready), 64'd0);
        chk("annul_end_stall", 64'(stallreq), 64'd1);
        annul = 1'b0; start = 1'b0;
        tick();
        #1 chk("annul_end_next", 64'(ready), 64'd0);

        // Back-to-back with start held across END.
        run_div("b2b_20_6", 32'd20, 32'd6, 1'b0, {32'd2, 32'd3});
        tick();
        run_div("b2b_50_5", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10});
        start = 1'b0; tick();

        // Synchronous reset mid-operation.
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (5) tick();
        rst = 1'b1; start = 1'b0;
        tick();
        #1;
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_ready", 64'(ready), 64'd0);
        chk("rst_mid_stall", 64'(stallreq), 64'd0);
        rst = 1'b0;
        tick();
        run_div("post_rst_20_6", 32'd20, 32'd6, 1'b0, {32'd2, 32'd3});
        start = 1'b0; tick();

        // Random divides against the reference model.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            run_div($sformatf("rand%0d", i), ra, rb, rs, ref_div(ra, rb, rs));
            if ($urandom_range(0, 1) == 0) begin
                start = 1'b0;
            end
            tick();
        end

        start = 1'b0;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
